// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: CPU fetch/data, external loader and RAM signals of the memory sequencer
// slave:  sequencer side (takes requests and ram_rdata, drives stall, grants and the RAM strobes)
// master: environment side (CPU, loader and RAM model)
interface mem_sequencer_if #(parameter int AW = 10);
  logic [31:0] ifetch_addr;
  logic [31:0] ifetch_data;
  logic d_rd;
  logic d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic stall;
  logic ext_req;
  logic ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic ext_gnt;
  logic ext_rvalid;
  logic [31:0] ext_rdata;
  logic ram_en;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  modport slave (
    input ifetch_addr, d_rd, d_wr, d_addr, d_wdata, ext_req, ext_we, ext_addr, ext_wdata, ram_rdata,
    output ifetch_data, d_rdata, stall, ext_gnt, ext_rvalid, ext_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output ifetch_addr, d_rd, d_wr, d_addr, d_wdata, ext_req, ext_we, ext_addr, ext_wdata, ram_rdata,
    input ifetch_data, d_rdata, stall, ext_gnt, ext_rvalid, ext_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: shares one single-port sync RAM between CPU fetch, CPU load/store and an external port
// clk:   rising-edge clock
// reset: synchronous active-high reset
// bus:   slave modport carrying CPU fetch/data, external request/grant and RAM strobes
module mem_sequencer #(
  parameter int AW = 10
) (
  input logic clk,
  input logic reset,
  mem_sequencer_if.slave bus
);
  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] FWAIT = 3'd1;
  localparam logic [2:0] DEC   = 3'd2;
  localparam logic [2:0] DWAIT = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;
  localparam logic [2:0] EXT   = 3'd5;
  localparam logic [2:0] EXTW  = 3'd6;
  logic [2:0] state;
  logic [2:0] state_n;
  logic [31:0] instr_q;
  logic [31:0] d_rdata_q;
  // a store wins over a simultaneous load, so DWAIT is only reached for a pure load
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:   state_n = FWAIT;
      FWAIT:   state_n = DEC;
      DEC:     state_n = (bus.d_rd && !bus.d_wr) ? DWAIT : EXEC;
      DWAIT:   state_n = EXEC;
      EXEC:    state_n = bus.ext_req ? EXT : FETCH;
      EXT:     state_n = bus.ext_we ? FETCH : EXTW;
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      instr_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == FWAIT) instr_q <= bus.ram_rdata;
      if (state == DWAIT) d_rdata_q <= bus.ram_rdata;
    end
  end
  // strobes are gated by reset so an operation caught mid-flight has no effect on the RAM
  assign bus.ram_en = !reset && (state == FETCH || state == EXT || (state == DEC && (bus.d_rd || bus.d_wr)));
  assign bus.ram_we = !reset && ((state == DEC && bus.d_wr) || (state == EXT && bus.ext_we));
  assign bus.ram_addr = state == DEC ? bus.d_addr[AW-1:0] : state == EXT ? bus.ext_addr[AW-1:0] : bus.ifetch_addr[AW-1:0];
  assign bus.ram_wdata = state == EXT ? bus.ext_wdata : bus.d_wdata;
  assign bus.ext_gnt = !reset && state == EXT;
  assign bus.ext_rvalid = !reset && state == EXTW;
  assign bus.ext_rdata = bus.ram_rdata;
  assign bus.stall = reset || state != EXEC;
  assign bus.ifetch_data = instr_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: randomized self-checking bench for mem_sequencer against a shadow-memory instruction model
module tb_mem_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int gnt_cnt = 0;
  int commit_cnt = 0;
  logic [31:0] shadow [1024];
  logic [31:0] exp_d;
  logic [31:0] ram_mem [1024];
  logic bd_we = 1'b0;
  logic bd_init = 1'b0;
  logic [9:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  mem_sequencer_if #(.AW(10)) bus ();
  mem_sequencer #(.AW(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= seed(i);
    end else if (bd_we) ram_mem[bd_addr] <= bd_data;
    else if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  always @(posedge clk) begin
    if (bus.ext_gnt === 1'b1) gnt_cnt <= gnt_cnt + 1;
    if (bus.stall === 1'b0) commit_cnt <= commit_cnt + 1;
  end

  task automatic idle_inputs();
    bus.ifetch_addr = '0;
    bus.d_rd = 1'b0;
    bus.d_wr = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.ext_req = 1'b0;
    bus.ext_we = 1'b0;
    bus.ext_addr = '0;
    bus.ext_wdata = '0;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    shadow[a] = d;
    bd_addr = a;
    bd_data = d;
    bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    exp_d = '0;
    reset = 1'b0;
  endtask

  // One instruction from its FETCH cycle to the start of the next FETCH; called in the low phase of FETCH.
  task automatic run_instr(input logic [31:0] pc, input logic rd, input logic wr, input logic [31:0] da,
                           input logic [31:0] wd, input logic er, input logic ew, input logic edrop,
                           input logic [31:0] ea, input logic [31:0] ewd);
    logic [31:0] exp_i;
    int n;
    int wes;
    int strobes;
    int lat;
    exp_i = shadow[pc[9:0]];
    bus.ifetch_addr = pc;
    bus.d_rd = rd;
    bus.d_wr = wr;
    bus.d_addr = da;
    bus.d_wdata = wd;
    bus.ext_req = er;
    bus.ext_we = ew;
    bus.ext_addr = ea;
    bus.ext_wdata = ewd;
    #1;
    n_cmp++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== pc[9:0]) begin
      n_err++;
      $display("FAIL fetch: en=%b we=%b addr=%h, want en=1 we=0 addr=%h", bus.ram_en, bus.ram_we, bus.ram_addr, pc[9:0]);
    end
    n = 1;
    wes = 0;
    strobes = 0;
    while (bus.stall === 1'b1 && n < 12) begin
      @(negedge clk);
      #1;
      n++;
      if (n == 3) begin
        if (edrop) bus.ext_req = 1'b0;
        n_cmp++;
        if (bus.ifetch_data !== exp_i) begin
          n_err++;
          $display("FAIL instr_latch: got %h want %h", bus.ifetch_data, exp_i);
        end
        n_cmp++;
        if (bus.ram_en !== (rd | wr) || bus.ram_we !== wr || ((rd | wr) && bus.ram_addr !== da[9:0]) ||
            (wr && bus.ram_wdata !== wd)) begin
          n_err++;
          $display("FAIL dec_access: en=%b we=%b addr=%h wdata=%h, want en=%b we=%b addr=%h wdata=%h",
                   bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, rd | wr, wr, da[9:0], wd);
        end
      end
      if (bus.ram_we === 1'b1) wes++;
      if (bus.ext_gnt === 1'b1 || bus.ext_rvalid === 1'b1) strobes++;
    end
    lat = (rd && !wr) ? 5 : 4;
    n_cmp++;
    if (n != lat || bus.stall !== 1'b0) begin
      n_err++;
      $display("FAIL latency: commit in cycle %0d (stall=%b), want cycle %0d", n, bus.stall, lat);
    end
    n_cmp++;
    if (wes != (wr ? 1 : 0) || strobes != 0) begin
      n_err++;
      $display("FAIL strobes: we pulses %0d ext pulses %0d, want %0d and 0", wes, strobes, wr ? 1 : 0);
    end
    if (wr) shadow[da[9:0]] = wd;
    else if (rd) exp_d = shadow[da[9:0]];
    n_cmp++;
    if (bus.d_rdata !== exp_d) begin
      n_err++;
      $display("FAIL load_data: got %h want %h", bus.d_rdata, exp_d);
    end
    @(negedge clk);
    #1;
    if (er && !edrop) begin
      n_cmp++;
      if (bus.ext_gnt !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_we !== ew || bus.ram_addr !== ea[9:0] ||
          (ew && bus.ram_wdata !== ewd)) begin
        n_err++;
        $display("FAIL ext_grant: gnt=%b en=%b we=%b addr=%h wdata=%h, want gnt=1 en=1 we=%b addr=%h wdata=%h",
                 bus.ext_gnt, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, ew, ea[9:0], ewd);
      end
      if (ew) shadow[ea[9:0]] = ewd;
      else begin
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.ext_rvalid !== 1'b1 || bus.ext_rdata !== shadow[ea[9:0]] || bus.ram_we !== 1'b0) begin
          n_err++;
          $display("FAIL ext_read: rvalid=%b rdata=%h we=%b, want rvalid=1 rdata=%h we=0",
                   bus.ext_rvalid, bus.ext_rdata, bus.ram_we, shadow[ea[9:0]]);
        end
      end
      @(negedge clk);
    end else begin
      n_cmp++;
      if (bus.ext_gnt !== 1'b0 || bus.ext_rvalid !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_en !== 1'b1) begin
        n_err++;
        $display("FAIL no_ext: gnt=%b rvalid=%b we=%b en=%b, want 0 0 0 1 (next fetch)",
                 bus.ext_gnt, bus.ext_rvalid, bus.ram_we, bus.ram_en);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bd_init = 1'b1;
    @(negedge clk);
    bd_init = 1'b0;
    for (int i = 0; i < 1024; i++) shadow[i] = seed(i);
    poke(10'h000, 32'h0C00_0000);
    poke(10'h010, 32'hDEAD_BEEF);
    bus.d_wr = 1'b1;
    bus.ext_req = 1'b1;
    bus.ext_we = 1'b1;
    #1;
    n_cmp++;
    if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.ext_gnt !== 1'b0 || bus.ext_rvalid !== 1'b0 ||
        bus.stall !== 1'b1) begin
      n_err++;
      $display("FAIL reset_strobes: en=%b we=%b gnt=%b rvalid=%b stall=%b, want 0 0 0 0 1",
               bus.ram_en, bus.ram_we, bus.ext_gnt, bus.ext_rvalid, bus.stall);
    end
    n_cmp++;
    if (bus.ifetch_data !== 32'h0 || bus.d_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_regs: ifetch_data=%h d_rdata=%h, want 0 0", bus.ifetch_data, bus.d_rdata);
    end
    do_reset();
  endtask

  task automatic test_basic();
    run_instr(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (bus.ifetch_data !== 32'h0C00_0000) begin
      n_err++;
      $display("FAIL basic_instr: got %h want 0c000000", bus.ifetch_data);
    end
  endtask

  task automatic test_load();
    run_instr(32'h1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (bus.d_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL load_value: got %h want deadbeef", bus.d_rdata);
    end
  endtask

  task automatic test_store_ext();
    run_instr(32'h2, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    n_cmp++;
    if (shadow[10'h020] !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL store_model: got %h want 12345678", shadow[10'h020]);
    end
  endtask

  task automatic test_fairness();
    int g0;
    int c0;
    g0 = gnt_cnt;
    c0 = commit_cnt;
    for (int i = 0; i < 3; i++)
      run_instr(32'h3 + 32'(i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), $urandom);
    n_cmp++;
    if (gnt_cnt - g0 != 3 || commit_cnt - c0 != 3) begin
      n_err++;
      $display("FAIL fairness: grants %0d commits %0d, want 3 and 3", gnt_cnt - g0, commit_cnt - c0);
    end
  endtask

  task automatic test_conflict_wrap();
    logic [31:0] wd;
    wd = $urandom;
    run_instr(32'h6, 1'b1, 1'b1, 32'h400, wd, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (shadow[10'h000] !== wd) begin
      n_err++;
      $display("FAIL wrap_model: got %h want %h", shadow[10'h000], wd);
    end
  endtask

  task automatic test_reset_load();
    int c0;
    do_reset();
    c0 = commit_cnt;
    bus.ifetch_addr = 32'h30;
    bus.d_rd = 1'b1;
    bus.d_addr = 32'h10;
    bus.ext_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.d_rdata !== 32'h0 || bus.ram_we !== 1'b0 || bus.ext_gnt !== 1'b0 || bus.ext_rvalid !== 1'b0 ||
          (k >= 4 && (bus.stall !== 1'b1 || bus.ram_en !== 1'b0))) begin
        n_err++;
        $display("FAIL reset_load c%0d: d_rdata=%h we=%b gnt=%b rvalid=%b stall=%b en=%b", k,
                 bus.d_rdata, bus.ram_we, bus.ext_gnt, bus.ext_rvalid, bus.stall, bus.ram_en);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (commit_cnt != c0) begin
      n_err++;
      $display("FAIL reset_load_commit: %0d commits, want 0", commit_cnt - c0);
    end
    reset = 1'b0;
    bus.ext_req = 1'b0;
    exp_d = '0;
    run_instr(32'h30, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic er;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      er = 1'($urandom_range(0, 1));
      run_instr($urandom, op[0], op[1], $urandom, $urandom, er, 1'($urandom_range(0, 1)),
                er && ($urandom_range(0, 3) == 0), $urandom, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    exp_d = '0;
    test_reset();
    test_basic();
    test_load();
    test_store_ext();
    test_fairness();
    test_conflict_wrap();
    test_reset_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle memory sequencer that shares one single-port synchronous RAM between the CPU's instruction fetch, the CPU's data load/store port and an external loader/debug port. It sits between `cpu` and the RAM. It serialises every instruction into fetch, optional data access and commit phases, and gates CPU state updates through `stall`. External accesses are slotted between instructions, so neither side can starve the other.

## Interface
- `AW`, 10, RAM word-address width; only `addr[AW-1:0]` is used, upper bits are ignored.
- `clk`  in  1  clock; everything is updated on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ifetch_addr`  in  32  CPU `pc_out`, a word address.
- `ifetch_data`  out  32  latched instruction, fed to the CPU `instruction` input.
- `d_rd`, `d_wr`  in  1  CPU `mem_rd`/`mem_wr`.
- `d_addr`  in  32  CPU `ram_addr`.
- `d_wdata`  in  32  CPU `data_mem_in`.
- `d_rdata`  out  32  latched load data, fed to the CPU `data_mem_out` input.
- `stall`  out  1  when high, the CPU must not commit PC or register-file writes.
- `ext_req`  in  1  external access request, held until `ext_gnt`.
- `ext_we`  in  1  1 = write, 0 = read; held with `ext_req`.
- `ext_addr`  in  32  external word address.
- `ext_wdata`  in  32  external write data.
- `ext_gnt`  out  1  one-cycle pulse; the access is issued in this cycle.
- `ext_rvalid`  out  1  one-cycle pulse; `ext_rdata` is valid.
- `ext_rdata`  out  32  external read data.
- `ram_en`, `ram_we`  out  1  RAM enable and write enable.
- `ram_addr`  out  AW  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data; valid one cycle after the `ram_en` read cycle.

## Operation
- FSM states: FETCH, FWAIT, DEC, DWAIT, EXEC, EXT, EXTW.
- **FETCH**
  - Drives `ram_en=1`, `ram_we=0`, `ram_addr=ifetch_addr[AW-1:0]`.
  - Goes to FWAIT.
- **FWAIT**
  - `instr_q <= ram_rdata`.
  - Goes to DEC.
- **DEC**
  - The CPU decodes `instr_q`, so `d_*` are valid.
  - If `d_wr`: drive `ram_en=1`, `ram_we=1`, `ram_addr=d_addr`, `ram_wdata=d_wdata`, then go to EXEC.
  - Else if `d_rd`: drive a read of `d_addr`, then go to DWAIT.
  - Else go to EXEC.
  - `d_wr` has priority when both `d_wr` and `d_rd` are high; no read is issued in that case.
- **DWAIT**
  - `d_rdata_q <= ram_rdata`.
  - Goes to EXEC.
- **EXEC**
  - `stall=0`; the CPU commits at the end of this cycle.
  - If `ext_req`, go to EXT; else go to FETCH.
- **EXT**
  - Drives `ext_gnt=1`, `ram_en=1`, `ram_we=ext_we`, `ram_addr=ext_addr`, `ram_wdata=ext_wdata`.
  - Goes to EXTW if reading, else to FETCH.
- **EXTW**
  - Drives `ext_rvalid=1` and `ext_rdata=ram_rdata`.
  - Goes to FETCH.
- Output sources:
  - `ifetch_data=instr_q` and `d_rdata=d_rdata_q`.
  - Both registers hold their value until they are next loaded.
- Arbitration:
  - Priority is CPU first.
  - At most one external access is made per instruction.
  - `ext_req` is sampled only in EXEC.
  - If `ext_req` drops before EXEC, no access is made.
- Addresses wrap modulo 2^AW. No out-of-range error is raised.

## Timing
- **While `reset` is high**
  - Forced low: `ram_en`, `ram_we`, `ext_gnt`, `ext_rvalid`.
  - Forced high: `stall`.
  - State resets to FETCH.
  - Cleared to 0: `instr_q`, `d_rdata_q`.
- **Startup**
  - The first FETCH is issued in the first cycle after `reset` deasserts.
- **Per-instruction latency, from FETCH to the commit edge**
  - ALU/branch instruction: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - An external write adds 1 cycle; an external read adds 2 cycles.
- **`stall`**
  - It is low for exactly one cycle per instruction (EXEC) and high in all other states.
- **RAM write strobe**
  - `ram_we` is high for exactly one cycle per write.
  - It is never high in FETCH, FWAIT, DWAIT, EXEC or EXTW.
- **Reset mid-operation**
  - Aborts the operation at once.
  - No EXEC or `ext_rvalid` pulse is produced for the aborted operation.
  - A pending external request is not granted.
- **Output registration**
  - `ext_gnt`, `ext_rvalid` and all `ram_*` signals are decoded combinationally from the state register and inputs.
  - There are no combinational paths from `ram_rdata` to the CPU.

## Test plan
- **Basic instruction.** Stimulus: release reset with ram[0]=0x0C000000 (non-memory op).
  - Cycle 1: `ram_en=1`, `ram_addr=0`.
  - Cycle 3: `ifetch_data=0x0C000000`.
  - `stall` is low only in cycle 4.
  - Cycle 5 is a FETCH of the next PC.
- **Load.** Stimulus: `d_rd=1`, `d_addr=0x10`, ram[0x10]=0xDEADBEEF.
  - A read of address 0x10 is issued in DEC.
  - `d_rdata=0xDEADBEEF` in EXEC.
  - `stall` is low in cycle 5 of the instruction.
- **Store then external readback.** Stimulus: `d_wr=1`, `d_addr=0x20`, `d_wdata=0x12345678`, then an external read of 0x20.
  - One `ram_we` pulse occurs, in DEC.
  - `ext_rvalid` occurs with `ext_rdata=0x12345678`.
- **Fairness under continuous external requests.** Stimulus: `ext_req` held high with `ext_we=1` across 3 instructions.
  - Exactly 3 `ext_gnt` pulses, each in the cycle right after an EXEC.
  - The CPU commits 3 times.
- **Read/write conflict and address wrap.** Stimulus: `d_rd=d_wr=1`, `d_addr=0x400` (AW=10).
  - A write to word 0 occurs.
  - No DWAIT state is entered.
  - The instruction takes 4 cycles.
- **Reset during a load.** Stimulus: assert `reset` in DWAIT.
  - The next cycle is FETCH after release.
  - No EXEC occurs for the aborted load.
  - `d_rdata=0` and `ram_we=0` throughout.
